// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-ported memory.
// Port 0 is the CPU, port 1 the auxiliary loader/DMA. Each transaction takes
// IDLE -> ISSUE -> RESP; ISSUE drives the memory for one cycle and RESP returns
// the one-cycle ack (plus read data). RESP may hand over straight to the other
// port, so alternating traffic is served at two cycles per transaction.
//
// Build option: define MEM_ARBITER_FIXED_PRIO_EN to make port 0 win every IDLE
// tie (no last_grant register). RESP handover to the waiting port is kept.
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [1:0]    cmd0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [1:0]    cmd1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t        state_q;
    state_t        state_d;

    // Latched transaction of the granted port. These only change on the edge
    // that enters ISSUE, so outside ISSUE they naturally hold the last value
    // that was presented to the memory.
    logic [1:0]    lat_cmd_q;
    logic [AW-1:0] lat_addr_q;
    logic [DW-1:0] lat_wdata_q;
    logic          grant_q;      // port owning the in-flight transaction

    logic          load;         // capture a new request this cycle
    logic          load_port;    // which port is captured
    logic          tie_winner;   // winner when both ports request in IDLE
    logic [DW-1:0] resp_data;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    assign tie_winner = 1'b0;
`else
    logic          last_grant_q;
    assign tie_winner = ~last_grant_q;
`endif

    // Read data returned with the ack: memory data for reads, zero otherwise.
    assign resp_data = (lat_cmd_q == CMD_READ) ? mem_rdata : '0;

    // Memory address and write data come straight from the latched request.
    assign mem_addr  = lat_addr_q;
    assign mem_wdata = lat_wdata_q;

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction capture and grant bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: the datapath is reset as well, so mem_addr/mem_wdata read 0
        // after reset instead of leftover values from an abandoned request.
        if (reset) begin
            lat_cmd_q    <= CMD_NONE;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            grant_q      <= 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else if (load) begin
            lat_cmd_q    <= load_port ? cmd1   : cmd0;
            lat_addr_q   <= load_port ? addr1  : addr0;
            lat_wdata_q  <= load_port ? wdata1 : wdata0;
            grant_q      <= load_port;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last_grant_q <= load_port;
`endif
        end
    end

    // Next-state, arbitration and output decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        load      = 1'b0;
        load_port = 1'b0;
        mem_cmd   = CMD_NONE;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    load      = 1'b1;
                    load_port = (req0 && req1) ? tie_winner : req1;
                    state_d   = ISSUE;
                end
            end

            ISSUE: begin
                // None/reserved commands are granted but never reach memory.
                if (lat_cmd_q == CMD_READ || lat_cmd_q == CMD_WRITE) begin
                    mem_cmd = lat_cmd_q;
                end
                state_d = RESP;
            end

            RESP: begin
                if (grant_q) begin
                    ack1   = 1'b1;
                    rdata1 = resp_data;
                end else begin
                    ack0   = 1'b1;
                    rdata0 = resp_data;
                end
                // Only the other port is eligible; the just-acked port's req
                // is still its old request in this cycle.
                if (grant_q ? req0 : req1) begin
                    load      = 1'b1;
                    load_port = ~grant_q;
                    state_d   = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Safety properties: acks are exclusive and memory is only driven in ISSUE.
    assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
    assert property (@(posedge clk) disable iff (reset)
                     (mem_cmd != CMD_NONE) |-> (state_q == ISSUE));

endmodule
